// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect/hold control: branch, load-use hold, interrupt entry (drain/save/vector) and return.
// Latency: all Fetch-facing outputs are combinational; entry takes DRAIN_CYCLES+2 cycles from accept to vector.
// Backpressure: none accepted; stall is the hold this block applies to Fetch. Option: FETCH_REDIRECT_INT_PENDING_EN.
module fetch_redirect_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        load_use_hazard,
    input  logic        int_req,
    input  logic        rti,
    input  logic [31:0] pc_current,
    output logic        stall,
    output logic        jumpBit,
    output logic [31:0] branchIR,
    output logic        interruptBit,
    output logic        flush,
    output logic        push_pc_valid,
    output logic [31:0] push_pc,
    output logic        int_ack,
    output logic        in_isr
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_SAVE   = 2'd2;
    localparam logic [1:0] S_VECTOR = 2'd3;

    localparam logic [3:0] DCNT_INIT = 4'(DRAIN_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_dcnt;
    logic [31:0] r_ret_pc;
    logic        r_in_isr;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_dcnt_nxt;
    logic [31:0] w_ret_pc_nxt;
    logic        w_in_isr_nxt;
    logic        w_accept;
    logic        w_int_src;

    logic        w_stall;
    logic        w_jump;
    logic [31:0] w_branch_ir;
    logic        w_int_bit;
    logic        w_flush;
    logic        w_push_vld;
    logic        w_int_ack;

`ifdef FETCH_REDIRECT_INT_PENDING_EN
    logic r_pending;

    // Accept clears the sticky bit even if int_req is still high on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b0;
        end else if (int_req) begin
            r_pending <= 1'b1;
        end
    end

    assign w_int_src = int_req | r_pending;
`else
    assign w_int_src = int_req;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_dcnt_nxt   = r_dcnt;
        w_ret_pc_nxt = r_ret_pc;
        w_in_isr_nxt = r_in_isr;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        w_jump       = 1'b0;
        w_branch_ir  = 32'd0;
        w_int_bit    = 1'b0;
        w_flush      = 1'b0;
        w_push_vld   = 1'b0;
        w_int_ack    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (branch_taken) begin
                    w_jump      = 1'b1;
                    w_branch_ir = branch_target;
                    w_flush     = 1'b1;
                end else if (rti && r_in_isr) begin
                    w_jump       = 1'b1;
                    w_branch_ir  = r_ret_pc;
                    w_flush      = 1'b1;
                    w_in_isr_nxt = 1'b0;
                end else if (w_int_src && !r_in_isr) begin
                    w_accept     = 1'b1;
                    w_int_ack    = 1'b1;
                    w_stall      = 1'b1;
                    w_ret_pc_nxt = pc_current;
                    w_dcnt_nxt   = DCNT_INIT;
                    w_state_nxt  = S_DRAIN;
                end else if (load_use_hazard) begin
                    w_stall = 1'b1;
                end
            end
            S_DRAIN: begin
                w_stall = 1'b1;
                // A branch resolving under the drain becomes the return point.
                if (branch_taken) begin
                    w_ret_pc_nxt = branch_target;
                    w_flush      = 1'b1;
                end
                if (r_dcnt == 4'd0) begin
                    w_state_nxt = S_SAVE;
                end else begin
                    w_dcnt_nxt = r_dcnt - 4'd1;
                end
            end
            S_SAVE: begin
                w_stall     = 1'b1;
                w_push_vld  = 1'b1;
                w_state_nxt = S_VECTOR;
            end
            default: begin
                w_int_bit    = 1'b1;
                w_flush      = 1'b1;
                w_in_isr_nxt = 1'b1;
                w_state_nxt  = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_dcnt   <= 4'd0;
            r_ret_pc <= 32'd0;
            r_in_isr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_ret_pc <= w_ret_pc_nxt;
            r_in_isr <= w_in_isr_nxt;
        end
    end

    // Outputs are forced low during reset even though inputs may be active.
    assign stall         = rst & w_stall;
    assign jumpBit       = rst & w_jump;
    assign branchIR      = rst ? w_branch_ir : 32'd0;
    assign interruptBit  = rst & w_int_bit;
    assign flush         = rst & w_flush;
    assign push_pc_valid = rst & w_push_vld;
    assign push_pc       = rst ? r_ret_pc : 32'd0;
    assign int_ack       = rst & w_int_ack;
    assign in_isr        = rst & r_in_isr;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed entry/return sequence, then randomized traffic vs a cycle-offset model.
module tb_fetch_redirect_ctrl;

    localparam int D = 3;
`ifdef FETCH_REDIRECT_INT_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        load_use_hazard = 1'b0;
    logic        int_req = 1'b0;
    logic        rti = 1'b0;
    logic [31:0] pc_current = 32'd0;
    logic        stall, jumpBit, interruptBit, flush, push_pc_valid, int_ack, in_isr;
    logic [31:0] branchIR, push_pc;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: m_ent is the number of cycles since interrupt accept (-1 when not sequencing).
    int          m_ent  = -1;
    logic [31:0] m_ret  = 32'd0;
    logic        m_isr  = 1'b0;
    logic        m_pend = 1'b0;

    fetch_redirect_ctrl #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .load_use_hazard(load_use_hazard), .int_req(int_req), .rti(rti),
        .pc_current(pc_current),
        .stall(stall), .jumpBit(jumpBit), .branchIR(branchIR),
        .interruptBit(interruptBit), .flush(flush),
        .push_pc_valid(push_pc_valid), .push_pc(push_pc),
        .int_ack(int_ack), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check every output against the model, then advance the model.
    task automatic step(input logic r, input logic bt, input logic [31:0] tgt,
                        input logic lu, input logic ir, input logic rt, input logic [31:0] pc);
        logic        e_stall, e_jump, e_int, e_flush, e_push, e_ack;
        logic [31:0] e_bir, e_ppc;
        int          n_ent;
        logic [31:0] n_ret;
        logic        n_isr, n_pend, acc;
        @(negedge clk);
        rst = r; branch_taken = bt; branch_target = tgt; load_use_hazard = lu;
        int_req = ir; rti = rt; pc_current = pc;
        #1;
        e_stall = 0; e_jump = 0; e_int = 0; e_flush = 0; e_push = 0; e_ack = 0;
        e_bir = 0; e_ppc = 0; acc = 0;
        n_ent = m_ent; n_ret = m_ret; n_isr = m_isr; n_pend = m_pend;
        if (!r) begin
            n_ent = -1; n_ret = 0; n_isr = 0; n_pend = 0;
        end else begin
            e_ppc = m_ret;
            if (m_ent < 0) begin
                if (bt) begin
                    e_jump = 1; e_bir = tgt; e_flush = 1;
                end else if (rt && m_isr) begin
                    e_jump = 1; e_bir = m_ret; e_flush = 1; n_isr = 0;
                end else if ((ir || m_pend) && !m_isr) begin
                    e_ack = 1; e_stall = 1; n_ret = pc; n_ent = 1; acc = 1;
                end else if (lu) begin
                    e_stall = 1;
                end
            end else if (m_ent <= D) begin
                e_stall = 1;
                if (bt) begin
                    e_flush = 1; n_ret = tgt;
                end
                n_ent = m_ent + 1;
            end else if (m_ent == D + 1) begin
                e_stall = 1; e_push = 1; n_ent = m_ent + 1;
            end else begin
                e_int = 1; e_flush = 1; n_isr = 1; n_ent = -1;
            end
            if (PEND) n_pend = acc ? 1'b0 : (m_pend | ir);
        end
        chk1("stall", stall, e_stall);
        chk1("jumpBit", jumpBit, e_jump);
        chk32("branchIR", branchIR, e_bir);
        chk1("interruptBit", interruptBit, e_int);
        chk1("flush", flush, e_flush);
        chk1("push_pc_valid", push_pc_valid, e_push);
        chk32("push_pc", push_pc, e_ppc);
        chk1("int_ack", int_ack, e_ack);
        chk1("in_isr", in_isr, r ? m_isr : 1'b0);
        m_ent = n_ent; m_ret = n_ret; m_isr = n_isr; m_pend = n_pend;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 32'h24);
    endtask

    initial begin
        // Reset with active inputs: everything must read zero.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h40, 1, 1, 1, 32'h24);
        chk1("rst_jump", jumpBit, 1'b0);
        chk32("rst_bir", branchIR, 32'h0);
        step(1, 1, 32'h40, 0, 0, 0, 32'h24);
        chk1("first_branch_jump", jumpBit, 1'b1);
        chk32("first_branch_bir", branchIR, 32'h40);

        // One-cycle load-use hold.
        step(1, 0, 0, 1, 0, 0, 32'h24);
        chk1("hazard_stall", stall, 1'b1);
        idle(1);
        chk1("hazard_release", stall, 1'b0);

        // Entry with a branch resolving in the first drain cycle.
        idle(4);
        step(1, 0, 0, 0, 1, 0, 32'h24);
        chk1("entry_ack", int_ack, 1'b1);
        step(1, 1, 32'h80, 0, 0, 0, 32'h28);
        chk1("drain_branch_nojump", jumpBit, 1'b0);
        chk1("drain_branch_flush", flush, 1'b1);
        idle(D - 1);
        idle(1);
        chk1("save_strobe", push_pc_valid, 1'b1);
        chk32("save_pc_branch", push_pc, 32'h80);
        idle(1);
        chk1("vector", interruptBit, 1'b1);
        idle(1);
        chk1("isr_set", in_isr, 1'b1);
        step(1, 0, 0, 0, 0, 1, 32'h100);
        chk32("rti_target_branch", branchIR, 32'h80);
        idle(1);
        chk1("isr_clear", in_isr, 1'b0);

        // Plain entry, then a masked request during the handler.
        step(1, 0, 0, 0, 1, 0, 32'h24);
        idle(D + 2);
        idle(1);
        chk1("isr_set2", in_isr, 1'b1);
        step(1, 0, 0, 0, 1, 0, 32'h200);
        chk1("masked_req", int_ack, 1'b0);
        idle(3);
        step(1, 0, 0, 0, 0, 1, 32'h200);
        chk32("rti_target_saved", branchIR, 32'h24);
        step(1, 0, 0, 0, 0, 0, 32'h300);
        chk1("pending_after_rti", int_ack, PEND);
        idle(D + 4);

        // Randomized traffic including occasional mid-sequence resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 6) == 0), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
